// File: rtl/life_vga_renderer.sv
`default_nettype none
// ============================================================================
// Module   : life_vga_renderer
// Purpose  : Pixel pipeline between the VGA sync generator and the board pins.
//            Tracks the raster position as a 64x48 cell coordinate without a
//            divider, fetches the current board row through a one-cycle
//            synchronous read port, and emits registered RGB with a cursor
//            overlay. h/v sync are delayed by the same three clocks as the
//            colour, so all VGA pins change on the same edge. A once-per-frame
//            strobe marks the raster origin for the generation engine.
//
// Ports    : clk            pixel clock (same clock that advances counter_x)
//            reset_n        asynchronous, active-low reset
//            counter_x/y    raster column / line from the sync generator
//            in_display     high inside the 640x480 visible area
//            hsync_in       raw horizontal sync (polarity is passed through)
//            vsync_in       raw vertical sync (polarity is passed through)
//            cell_rd_row    board row address (registered)
//            cell_rd_data   board row word, valid 1 clk after cell_rd_row
//            cursor_x/y     cursor cell, quasi-static; out of range = hidden
//            vga_r/g/b      registered colour
//            vga_h_sync     hsync_in delayed 3 clk
//            vga_v_sync     vsync_in delayed 3 clk
//            frame_start    one-clk pulse, 1 clk after the raster origin
//
// Build    : LIFE_GRID_EN  when defined, dead cells draw a 1-pixel blue grid
//                          on their first column and first line. When
//                          undefined, vga_b is tied low.
//
// Revision : 1.0  initial release
// ============================================================================
module life_vga_renderer #(
  parameter int COLS    = 64,
  parameter int ROWS    = 48,
  parameter int CELL_PX = 10
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [9:0]                counter_x,
  input  logic [9:0]                counter_y,
  input  logic                      in_display,
  input  logic                      hsync_in,
  input  logic                      vsync_in,
  output logic [$clog2(ROWS)-1:0]   cell_rd_row,
  input  logic [COLS-1:0]           cell_rd_data,
  input  logic [$clog2(COLS)-1:0]   cursor_x,
  input  logic [$clog2(ROWS)-1:0]   cursor_y,
  output logic                      vga_r,
  output logic                      vga_g,
  output logic                      vga_b,
  output logic                      vga_h_sync,
  output logic                      vga_v_sync,
  output logic                      frame_start
);

  localparam int C_COL_W = $clog2(COLS);
  localparam int C_ROW_W = $clog2(ROWS);
  localparam int C_SUB_W = $clog2(CELL_PX);

  localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(COLS - 1);
  localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(ROWS - 1);
  localparam logic [C_SUB_W-1:0] C_SUB_LAST = C_SUB_W'(CELL_PX - 1);
  localparam logic [C_SUB_W-1:0] C_SUB_ZERO = '0;

  // --------------------------------------------------------------------------
  // Raster landmarks
  // --------------------------------------------------------------------------
  logic w_line_start;
  logic w_origin;

  assign w_line_start = (counter_x == 10'd0);
  assign w_origin     = w_line_start && (counter_y == 10'd0);

  // --------------------------------------------------------------------------
  // Stage 1: position tracking
  // The cell index is counted in CELL_PX-pixel steps instead of dividing the
  // raster counters. Columns restart at every line start; rows step once per
  // line and are only forced to zero at the frame origin, so after a
  // mid-frame reset the row index is exact again from the next origin.
  // --------------------------------------------------------------------------
  logic [C_COL_W-1:0] r_col_idx;
  logic [C_SUB_W-1:0] r_col_sub;
  logic [C_ROW_W-1:0] r_row_idx;
  logic [C_SUB_W-1:0] r_row_sub;
  logic               r_s1_de;
  logic               r_s1_hs;
  logic               r_s1_vs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col_idx <= '0;
      r_col_sub <= '0;
    end else if (w_line_start) begin
      r_col_idx <= '0;
      r_col_sub <= '0;
    end else if (r_col_sub == C_SUB_LAST) begin
      r_col_sub <= '0;
      // Saturate so an overrunning raster stays on the last column.
      if (r_col_idx != C_COL_LAST) begin
        r_col_idx <= r_col_idx + 1'b1;
      end
    end else begin
      r_col_sub <= r_col_sub + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_row_idx <= '0;
      r_row_sub <= '0;
    end else if (w_origin) begin
      r_row_idx <= '0;
      r_row_sub <= '0;
    end else if (w_line_start) begin
      if (r_row_sub == C_SUB_LAST) begin
        r_row_sub <= '0;
        // Saturate through vertical blanking.
        if (r_row_idx != C_ROW_LAST) begin
          r_row_idx <= r_row_idx + 1'b1;
        end
      end else begin
        r_row_sub <= r_row_sub + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_de <= 1'b0;
      r_s1_hs <= 1'b0;
      r_s1_vs <= 1'b0;
    end else begin
      r_s1_de <= in_display;
      r_s1_hs <= hsync_in;
      r_s1_vs <= vsync_in;
    end
  end

  // The row index register doubles as the read address, so the row word
  // for a line arrives one clock after the line-start sample.
  assign cell_rd_row = r_row_idx;

  // --------------------------------------------------------------------------
  // Stage 2: forward position and control to line up with cell_rd_data
  // --------------------------------------------------------------------------
  logic [C_COL_W-1:0] r_s2_col_idx;
  logic [C_SUB_W-1:0] r_s2_col_sub;
  logic [C_ROW_W-1:0] r_s2_row_idx;
  logic [C_SUB_W-1:0] r_s2_row_sub;
  logic               r_s2_de;
  logic               r_s2_hs;
  logic               r_s2_vs;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_col_idx <= '0;
      r_s2_col_sub <= '0;
      r_s2_row_idx <= '0;
      r_s2_row_sub <= '0;
      r_s2_de      <= 1'b0;
      r_s2_hs      <= 1'b0;
      r_s2_vs      <= 1'b0;
    end else begin
      r_s2_col_idx <= r_col_idx;
      r_s2_col_sub <= r_col_sub;
      // Row index is carried along too, so the pixels still draining from the
      // previous line are not compared against the next line's cursor row.
      r_s2_row_idx <= r_row_idx;
      r_s2_row_sub <= r_row_sub;
      r_s2_de      <= r_s1_de;
      r_s2_hs      <= r_s1_hs;
      r_s2_vs      <= r_s1_vs;
    end
  end

  // --------------------------------------------------------------------------
  // Stage 3: colour composition (cursor border > live cell > grid > black)
  // --------------------------------------------------------------------------
  logic w_live;
  logic w_cursor_cell;
  logic w_cell_border;
  logic w_cursor_px;
  logic w_red;
  logic w_green;

  assign w_live        = cell_rd_data[r_s2_col_idx];
  // An out-of-range cursor can never equal a saturated index, so it hides.
  assign w_cursor_cell = (r_s2_col_idx == cursor_x) && (r_s2_row_idx == cursor_y);
  assign w_cell_border = (r_s2_col_sub == C_SUB_ZERO) || (r_s2_col_sub == C_SUB_LAST) ||
                         (r_s2_row_sub == C_SUB_ZERO) || (r_s2_row_sub == C_SUB_LAST);
  assign w_cursor_px   = w_cursor_cell && w_cell_border;

  assign w_red   = r_s2_de && w_cursor_px;
  assign w_green = r_s2_de && !w_cursor_px && w_live;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_r      <= 1'b0;
      vga_g      <= 1'b0;
      vga_h_sync <= 1'b0;
      vga_v_sync <= 1'b0;
    end else begin
      vga_r      <= w_red;
      vga_g      <= w_green;
      vga_h_sync <= r_s2_hs;
      vga_v_sync <= r_s2_vs;
    end
  end

`ifdef LIFE_GRID_EN
  // Grid line on the first column and first line of every dead cell.
  logic w_blue;

  assign w_blue = r_s2_de && !w_cursor_px && !w_live &&
                  ((r_s2_col_sub == C_SUB_ZERO) || (r_s2_row_sub == C_SUB_ZERO));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_b <= 1'b0;
    end else begin
      vga_b <= w_blue;
    end
  end
`else
  assign vga_b = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Frame strobe: taken straight from the raster, not from the pixel pipe.
  // Edge-detected so a raster that lingers at the origin yields one pulse.
  // --------------------------------------------------------------------------
  logic r_origin_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_origin_d  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      r_origin_d  <= w_origin;
      frame_start <= w_origin && !r_origin_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_life_vga_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_vga_renderer
// Purpose  : Self-checking bench for life_vga_renderer. A bench-side raster
//            generator drives frames of various sizes; expected pixels are
//            computed arithmetically from (x, y), the board and the cursor,
//            then compared 3 clk later. Also covers reset, sync delay,
//            frame strobe and read-row addressing.
// Revision : 1.0  initial release
// ============================================================================
module tb_life_vga_renderer;

  localparam int COLS    = 64;
  localparam int ROWS    = 48;
  localparam int CELL_PX = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [9:0]  counter_x = '0;
  logic [9:0]  counter_y = '0;
  logic        in_display = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [5:0]  cell_rd_row;
  logic [63:0] cell_rd_data = '0;
  logic [5:0]  cursor_x = '0;
  logic [5:0]  cursor_y = '0;
  logic        vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_start;

  logic [63:0] board [0:ROWS-1];

  int n_cmp = 0;
  int n_err = 0;

  life_vga_renderer #(
    .COLS    (COLS),
    .ROWS    (ROWS),
    .CELL_PX (CELL_PX)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .counter_x    (counter_x),
    .counter_y    (counter_y),
    .in_display   (in_display),
    .hsync_in     (hsync_in),
    .vsync_in     (vsync_in),
    .cell_rd_row  (cell_rd_row),
    .cell_rd_data (cell_rd_data),
    .cursor_x     (cursor_x),
    .cursor_y     (cursor_y),
    .vga_r        (vga_r),
    .vga_g        (vga_g),
    .vga_b        (vga_b),
    .vga_h_sync   (vga_h_sync),
    .vga_v_sync   (vga_v_sync),
    .frame_start  (frame_start)
  );

  always #5 clk = ~clk;

  // One-cycle synchronous board memory.
  always @(posedge clk) begin
    if (int'(cell_rd_row) < ROWS) cell_rd_data <= board[cell_rd_row];
    else                          cell_rd_data <= '0;
  end

  typedef struct packed {
    logic [2:0] rgb;
    logic       hs;
    logic       vs;
    logic       origin;
    logic [5:0] row;
  } pix_t;

  // h0 = most recently driven raster sample, h2 = two samples older.
  pix_t h0 = '0;
  pix_t h1 = '0;
  pix_t h2 = '0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h (x=%0d y=%0d)",
               tag, $time, got, exp, counter_x, counter_y);
    end
  endtask

  function automatic int row_of(int y);
    int r;
    r = y / CELL_PX;
    if (r > ROWS - 1) r = ROWS - 1;
    return r;
  endfunction

  // Expected {r,g,b} for raster point (x, y).
  function automatic logic [2:0] model_rgb(int x, int y, bit de);
    int  col, row, cs, rs;
    bit  on_border;
    if (!de) return 3'b000;
    col = x / CELL_PX;
    if (col > COLS - 1) col = COLS - 1;
    row = row_of(y);
    cs  = x % CELL_PX;
    rs  = y % CELL_PX;
    on_border = (col == int'(cursor_x)) && (row == int'(cursor_y)) &&
                (cs == 0 || cs == CELL_PX - 1 || rs == 0 || rs == CELL_PX - 1);
    if (on_border) return 3'b100;
    if (board[row][col]) return 3'b010;
`ifdef LIFE_GRID_EN
    if (cs == 0 || rs == 0) return 3'b001;
`endif
    return 3'b000;
  endfunction

  task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs);
    counter_x  = 10'(x);
    counter_y  = 10'(y);
    in_display = de;
    hsync_in   = hs;
    vsync_in   = vs;
    h2 = h1;
    h1 = h0;
    h0.rgb    = model_rgb(x, y, de);
    h0.hs     = hs;
    h0.vs     = vs;
    h0.origin = (x == 0) && (y == 0);
    h0.row    = 6'(row_of(y));
  endtask

  task automatic cycle_check();
    @(posedge clk);
    #1;
    check_val("rgb",         {vga_r, vga_g, vga_b}, h2.rgb);
    check_val("h_sync",      vga_h_sync,            h2.hs);
    check_val("v_sync",      vga_v_sync,            h2.vs);
    check_val("frame_start", frame_start,           h0.origin && !h1.origin);
    check_val("rd_row",      cell_rd_row,           h0.row);
  endtask

  // Runs one raster frame; limit >= 0 stops after that many samples.
  task automatic run_frame(input int hv, input int ht, input int vv, input int vt,
                           input int limit, input bit count_fs);
    int fs_seen = 0;
    int n = 0;
    bit hp = 1'($urandom);
    bit vp = 1'($urandom);
    for (int y = 0; y < vt; y++) begin
      for (int x = 0; x < ht; x++) begin
        if (n == limit) return;
        drive(x, y, (x < hv) && (y < vv),
              ((x >= hv + 2) && (x < hv + 6)) ^ hp,
              ((y >= vv + 1) && (y < vv + 3)) ^ vp);
        cycle_check();
        if (frame_start) fs_seen++;
        n++;
      end
    end
    if (count_fs) check_val("frame_start_count", 64'(fs_seen), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_start, cell_rd_row}, '0);
  endtask

  // Asserts reset between clock edges, checks outputs clear without an edge,
  // holds for two edges, then releases just after an edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_all_zero("reset_async");
    repeat (2) begin
      @(posedge clk);
      #1;
      check_all_zero("reset_hold");
    end
    reset_n = 1'b1;
    h0 = '0;
    h1 = '0;
    h2 = '0;
  endtask

  task automatic clear_board();
    for (int r = 0; r < ROWS; r++) board[r] = '0;
  endtask

  task automatic random_board();
    for (int r = 0; r < ROWS; r++) board[r] = {$urandom, $urandom} & {$urandom, $urandom};
  endtask

  initial begin
    clear_board();
    #1;
    do_reset();

    // Single live cell at row 5, column 7; cursor parked off the board.
    board[5][7] = 1'b1;
    cursor_x = 6'd63;
    cursor_y = 6'd63;
    run_frame(160, 176, 80, 84, -1, 1'b1);

    // Cursor at (0,0) on an empty board.
    clear_board();
    cursor_x = 6'd0;
    cursor_y = 6'd0;
    run_frame(40, 48, 30, 32, -1, 1'b1);

    // Cursor on a live cell: border red, interior green.
    board[1][2] = 1'b1;
    board[0][0] = 1'b1;
    cursor_x = 6'd2;
    cursor_y = 6'd1;
    run_frame(40, 48, 30, 32, -1, 1'b1);

    // Random board and cursor.
    random_board();
    cursor_x = 6'($urandom_range(0, 19));
    cursor_y = 6'($urandom_range(0, 5));
    run_frame(200, 216, 60, 64, -1, 1'b1);

    // Full-width lines with column overrun past 639.
    random_board();
    cursor_x = 6'd63;
    cursor_y = 6'd0;
    run_frame(640, 680, 4, 6, -1, 1'b1);

    // Full height with blanking lines: row index saturates at 47.
    random_board();
    cursor_x = 6'd1;
    cursor_y = 6'd47;
    run_frame(16, 24, 480, 500, -1, 1'b1);

    // Reset in the middle of a visible line, then a fresh frame.
    random_board();
    cursor_x = 6'($urandom_range(0, 3));
    cursor_y = 6'($urandom_range(0, 2));
    run_frame(40, 48, 30, 32, 48 * 20 + 17, 1'b0);
    #3;
    do_reset();
    run_frame(40, 48, 30, 32, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
